pe_array_seq: RTL and testbench



---
 rtl/pe_array_seq_if.sv | 52 +++++
 rtl/pe_array_seq.sv | 146 ++++++++++++++
 tb/tb_pe_array_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_seq_if.sv
// Signal bundle between the PE-array sequencer and its neighbours: start/config, IFM and weight streams,
// PE array drive and return, and the OFM result handshake. master drives the sequencer inputs, slave is the sequencer.
interface pe_array_seq_if #(
  parameter int NUM_PE = 256,
  parameter int DATA_W = 8,
  parameter int K_W    = 12
);
  logic                       start;
  logic [K_W-1:0]             k_len;
  logic [NUM_PE-1:0]          lane_mask;

  logic                       ifm_vld;
  logic                       ifm_rdy;
  logic [NUM_PE*DATA_W-1:0]   ifm_data;

  logic                       wgt_vld;
  logic                       wgt_rdy;
  logic [DATA_W-1:0]          wgt_data;

  logic [NUM_PE*DATA_W-1:0]   pe_ifm;
  logic [DATA_W-1:0]          pe_weight;
  logic [NUM_PE-1:0]          pe_en;
  logic [NUM_PE-1:0]          pe_finish;
  logic [NUM_PE-1:0]          pe_valid;
  logic [NUM_PE*DATA_W-1:0]   pe_ofm;

  logic                       ofm_vld;
  logic                       ofm_rdy;
  logic [NUM_PE*DATA_W-1:0]   ofm_data;

  logic                       busy;
  logic                       done;
  logic                       timeout;

  modport master (
    output start, k_len, lane_mask,
    output ifm_vld, ifm_data, wgt_vld, wgt_data,
    output pe_valid, pe_ofm, ofm_rdy,
    input  ifm_rdy, wgt_rdy,
    input  pe_ifm, pe_weight, pe_en, pe_finish,
    input  ofm_vld, ofm_data, busy, done, timeout
  );

  modport slave (
    input  start, k_len, lane_mask,
    input  ifm_vld, ifm_data, wgt_vld, wgt_data,
    input  pe_valid, pe_ofm, ofm_rdy,
    output ifm_rdy, wgt_rdy,
    output pe_ifm, pe_weight, pe_en, pe_finish,
    output ofm_vld, ofm_data, busy, done, timeout
  );
endinterface

// File: rtl/pe_array_seq.sv
// Sequences k_len joint IFM/weight steps into the 256-lane PE array, then collects the masked OFM vector.
// Latency: start->busy 1 cycle, fire->pe_en 1 cycle, lanes valid->ofm_vld 1 cycle (timeout after DRAIN_TO+1).
// Backpressure: IFM and weight only transfer together in RUN; ofm_vld/ofm_data hold until ofm_rdy.
module pe_array_seq #(
  parameter int NUM_PE   = 256,
  parameter int DATA_W   = 8,
  parameter int K_W      = 12,
  parameter int DRAIN_TO = 64
) (
  input  logic          core_clk,
  input  logic          reset,
  pe_array_seq_if.slave bus
);

  localparam int VEC_W = NUM_PE * DATA_W;
  localparam int DC_W  = $clog2(DRAIN_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t              state;
  logic [K_W-1:0]      k_len_q;
  logic [K_W-1:0]      step_q;
  logic [NUM_PE-1:0]   mask_q;
  logic [DC_W-1:0]     drain_cnt;

  logic [VEC_W-1:0]    pe_ifm_q;
  logic [DATA_W-1:0]   pe_weight_q;
  logic [NUM_PE-1:0]   pe_en_q;
  logic [NUM_PE-1:0]   pe_finish_q;
  logic                ofm_vld_q;
  logic [VEC_W-1:0]    ofm_data_q;
  logic                busy_q;
  logic                timeout_q;

  logic                fire;
  logic                last_step;
  logic                lanes_ok;
  logic                drain_expired;
  logic [VEC_W-1:0]    ofm_masked;

  // Joint transfer: each stream is only ready when the other one is offering data.
  assign fire          = (state == S_RUN) && bus.ifm_vld && bus.wgt_vld;
  assign last_step     = (step_q + K_W'(1)) == k_len_q;
  assign lanes_ok      = (bus.pe_valid & mask_q) == mask_q;
  assign drain_expired = drain_cnt == DC_W'(DRAIN_TO);

  always_comb begin
    ofm_masked = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (mask_q[i]) begin
        ofm_masked[i*DATA_W +: DATA_W] = bus.pe_ofm[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      k_len_q     <= '0;
      step_q      <= '0;
      mask_q      <= '0;
      drain_cnt   <= '0;
      pe_ifm_q    <= '0;
      pe_weight_q <= '0;
      pe_en_q     <= '0;
      pe_finish_q <= '0;
      ofm_vld_q   <= 1'b0;
      ofm_data_q  <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pe_en_q     <= '0;
      pe_finish_q <= '0;

      case (state)
        S_IDLE: begin
          if (bus.start && (bus.k_len != '0)) begin
            k_len_q   <= bus.k_len;
            mask_q    <= bus.lane_mask;
            step_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= S_RUN;
          end
        end

        S_RUN: begin
          if (fire) begin
            pe_ifm_q    <= bus.ifm_data;
            pe_weight_q <= bus.wgt_data;
            pe_en_q     <= mask_q;
            step_q      <= step_q + K_W'(1);
            if (last_step) begin
              pe_finish_q <= mask_q;
              drain_cnt   <= '0;
              state       <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Lane completion wins over an expiring counter in the same cycle.
          if (lanes_ok || drain_expired) begin
            ofm_data_q <= ofm_masked;
            ofm_vld_q  <= 1'b1;
            if (!lanes_ok) begin
              timeout_q <= 1'b1;
            end
            state <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end

        S_OUT: begin
          if (bus.ofm_rdy) begin
            ofm_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ifm_rdy   = (state == S_RUN) && bus.wgt_vld;
  assign bus.wgt_rdy   = (state == S_RUN) && bus.ifm_vld;
  assign bus.pe_ifm    = pe_ifm_q;
  assign bus.pe_weight = pe_weight_q;
  assign bus.pe_en     = pe_en_q;
  assign bus.pe_finish = pe_finish_q;
  assign bus.ofm_vld   = ofm_vld_q;
  assign bus.ofm_data  = ofm_data_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  // Pulses in the accepting cycle itself, so it is qualified by the live ofm_rdy.
  assign bus.done      = ofm_vld_q && bus.ofm_rdy;

endmodule

// File: tb/tb_pe_array_seq.sv
// Randomised bench for pe_array_seq: each scenario task drives the streams and the lane model
// and compares against expectations derived from step counts, masks and cycle offsets.
module tb_pe_array_seq;

  localparam int NPE = 256;
  localparam int DW  = 8;
  localparam int VW  = NPE * DW;

  logic core_clk = 1'b0;
  logic reset    = 1'b1;
  int   total    = 0;
  int   bad      = 0;

  always #5 core_clk = ~core_clk;

  pe_array_seq_if #(.NUM_PE(NPE), .DATA_W(DW), .K_W(12)) bus ();

  pe_array_seq #(.NUM_PE(NPE), .DATA_W(DW), .K_W(12), .DRAIN_TO(64)) dut (
    .core_clk (core_clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NPE-1:0] rand_mask();
    logic [NPE-1:0] m;
    for (int w = 0; w < NPE / 32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [VW-1:0] keep_lanes(input logic [VW-1:0] v, input logic [NPE-1:0] m);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NPE; i++) if (m[i]) r[i*DW +: DW] = v[i*DW +: DW];
    return r;
  endfunction

  function automatic logic [VW-1:0] lane_index_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NPE; i++) v[i*DW +: DW] = 8'(i);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill55();
    logic [VW-1:0] v;
    for (int i = 0; i < NPE; i++) v[i*DW +: DW] = 8'h55;
    return v;
  endfunction

  function automatic bit stream_vld(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return $urandom_range(99) < 70;
  endfunction

  // One complete job. vmode: 0 always valid, 1 valid every other cycle, 2 random.
  // vdelay: DRAIN cycle at which the active lanes report valid (<0 never).
  task automatic run_job(input string tag, input int k, input logic [NPE-1:0] mask,
                         input int imode, input int wmode, input int vdelay,
                         input int stall, input bit fixed_pat);
    logic [VW-1:0] ifm_v, exp_ifm, ofm_in, exp_ofm;
    logic [DW-1:0] wgt_v, exp_wgt;
    bit            prev_fire, exp_to, exited;
    int            fires, cyc;

    bus.start = 1'b1; bus.k_len = 12'(k); bus.lane_mask = mask;
    bus.ifm_vld = 1'b0; bus.wgt_vld = 1'b0; bus.ofm_rdy = 1'b0; bus.pe_valid = '0;
    tick();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%0b exp=1", tag, bus.busy); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL %s timeout_cleared got=%0b exp=0", tag, bus.timeout); end

    fires = 0; cyc = 0; prev_fire = 1'b0; exp_ifm = '0; exp_wgt = '0;
    ifm_v = fixed_pat ? lane_index_vec() : rand_vec();
    wgt_v = fixed_pat ? 8'd1 : 8'($urandom);
    while (fires < k && cyc < 400) begin
      bus.ifm_vld = stream_vld(imode, cyc);
      bus.wgt_vld = stream_vld(wmode, cyc);
      bus.ifm_data = ifm_v; bus.wgt_data = wgt_v;
      #1;
      total++; if (bus.ifm_rdy !== bus.wgt_vld || bus.wgt_rdy !== bus.ifm_vld) begin
        bad++; $display("FAIL %s run_rdy cyc=%0d got ifm_rdy=%0b wgt_rdy=%0b exp %0b %0b", tag, cyc, bus.ifm_rdy, bus.wgt_rdy, bus.wgt_vld, bus.ifm_vld); end
      total++; if (bus.pe_en !== (prev_fire ? mask : '0) || bus.pe_finish !== '0) begin
        bad++; $display("FAIL %s run_pe_en cyc=%0d got en=%h fin=%h prev_fire=%0b", tag, cyc, bus.pe_en, bus.pe_finish, prev_fire); end
      if (prev_fire) begin
        total++; if (bus.pe_ifm !== exp_ifm || bus.pe_weight !== exp_wgt) begin
          bad++; $display("FAIL %s run_data cyc=%0d got w=%h ifm_lo=%h exp w=%h ifm_lo=%h", tag, cyc, bus.pe_weight, bus.pe_ifm[63:0], exp_wgt, exp_ifm[63:0]); end
      end
      prev_fire = bus.ifm_vld && bus.wgt_vld;
      if (prev_fire) begin
        exp_ifm = ifm_v; exp_wgt = wgt_v; fires++;
        ifm_v = fixed_pat ? lane_index_vec() : rand_vec();
        wgt_v = fixed_pat ? 8'(fires + 1) : 8'($urandom);
      end
      tick();
      cyc++;
    end

    // First DRAIN cycle: the last step's enable and finish strobe.
    bus.ifm_vld = 1'b1; bus.wgt_vld = 1'b1;
    #1;
    total++; if (bus.pe_en !== mask || bus.pe_finish !== mask) begin
      bad++; $display("FAIL %s last_step got en=%h fin=%h exp=%h", tag, bus.pe_en, bus.pe_finish, mask); end
    total++; if (bus.pe_ifm !== exp_ifm || bus.pe_weight !== exp_wgt) begin
      bad++; $display("FAIL %s last_data got w=%h exp w=%h", tag, bus.pe_weight, exp_wgt); end

    exited = 1'b0; exp_to = 1'b0; exp_ofm = '0;
    for (int d = 0; d <= 70 && !exited; d++) begin
      bus.pe_valid = (vdelay >= 0 && d >= vdelay) ? mask : ~mask;
      ofm_in = fixed_pat ? fill55() : rand_vec();
      bus.pe_ofm = ofm_in;
      #1;
      total++; if (bus.ifm_rdy !== 1'b0 || bus.wgt_rdy !== 1'b0 || bus.ofm_vld !== 1'b0 || bus.timeout !== 1'b0) begin
        bad++; $display("FAIL %s drain d=%0d got rdy=%0b%0b ofm_vld=%0b timeout=%0b exp all 0", tag, d, bus.ifm_rdy, bus.wgt_rdy, bus.ofm_vld, bus.timeout); end
      if (d > 0) begin
        total++; if (bus.pe_en !== '0 || bus.pe_finish !== '0) begin
          bad++; $display("FAIL %s drain_en d=%0d got en=%h fin=%h exp 0", tag, d, bus.pe_en, bus.pe_finish); end
      end
      if (mask == '0 || (vdelay >= 0 && d >= vdelay)) begin
        exited = 1'b1;
      end else if (d == 64) begin
        exited = 1'b1; exp_to = 1'b1;
      end
      if (exited) exp_ofm = keep_lanes(ofm_in, mask);
      tick();
    end
    bus.pe_valid = '0;

    for (int s = 0; s <= stall; s++) begin
      bus.ofm_rdy = (s == stall);
      bus.start = (s < stall); bus.k_len = 12'd5;
      bus.pe_ofm = rand_vec();
      #1;
      total++; if (bus.ofm_vld !== 1'b1 || bus.ofm_data !== exp_ofm) begin
        bad++; $display("FAIL %s out s=%0d got vld=%0b data_lo=%h exp vld=1 data_lo=%h", tag, s, bus.ofm_vld, bus.ofm_data[63:0], exp_ofm[63:0]); end
      total++; if (bus.done !== (s == stall) || bus.timeout !== exp_to || bus.busy !== 1'b1) begin
        bad++; $display("FAIL %s out_ctl s=%0d got done=%0b timeout=%0b busy=%0b exp %0b %0b 1", tag, s, bus.done, bus.timeout, bus.busy, (s == stall), exp_to); end
      tick();
    end
    bus.ofm_rdy = 1'b0; bus.start = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.ofm_vld !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== exp_to) begin
      bad++; $display("FAIL %s after got busy=%0b vld=%0b done=%0b timeout=%0b exp 0 0 0 %0b", tag, bus.busy, bus.ofm_vld, bus.done, bus.timeout, exp_to); end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.k_len = '0; bus.lane_mask = '0;
    bus.ifm_vld = 1'b1; bus.wgt_vld = 1'b1; bus.ifm_data = rand_vec(); bus.wgt_data = '0;
    bus.pe_valid = '0; bus.pe_ofm = '0; bus.ofm_rdy = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0 || bus.ofm_vld !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got busy=%0b vld=%0b done=%0b timeout=%0b exp 0", bus.busy, bus.ofm_vld, bus.done, bus.timeout); end
    total++; if (bus.pe_en !== '0 || bus.pe_finish !== '0 || bus.ifm_rdy !== 1'b0 || bus.wgt_rdy !== 1'b0) begin
      bad++; $display("FAIL reset_pe got en=%h fin=%h rdy=%0b%0b exp 0", bus.pe_en, bus.pe_finish, bus.ifm_rdy, bus.wgt_rdy); end
    total++; if (bus.pe_ifm !== '0 || bus.pe_weight !== '0 || bus.ofm_data !== '0) begin
      bad++; $display("FAIL reset_data got w=%h ifm_lo=%h ofm_lo=%h exp 0", bus.pe_weight, bus.pe_ifm[63:0], bus.ofm_data[63:0]); end
    reset = 1'b0; bus.ifm_vld = 1'b0; bus.wgt_vld = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_job("basic", 9, '1, 0, 0, 3, 0, 1'b1);
  endtask

  task automatic test_stall();
    run_job("stall", 4, '1, 0, 1, 1, 0, 1'b0);
  endtask

  task automatic test_mask();
    run_job("mask", 6, 256'hFF, 2, 2, 2, 0, 1'b1);
  endtask

  task automatic test_out_stall();
    run_job("out_stall", 3, rand_mask(), 0, 0, 0, 10, 1'b0);
  endtask

  task automatic test_timeout();
    run_job("timeout", 2, rand_mask() | 256'h1, 0, 0, -1, 1, 1'b0);
    run_job("post_timeout", 1, rand_mask(), 2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_zero_mask();
    run_job("zero_mask", 5, '0, 2, 2, -1, 0, 1'b0);
  endtask

  task automatic test_abort_reset();
    bus.start = 1'b1; bus.k_len = 12'd0; bus.lane_mask = '1;
    tick();
    bus.start = 1'b0; bus.ifm_vld = 1'b1; bus.wgt_vld = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.ifm_rdy !== 1'b0) begin
      bad++; $display("FAIL k0_start got busy=%0b ifm_rdy=%0b exp 0 0", bus.busy, bus.ifm_rdy); end
    bus.start = 1'b1; bus.k_len = 12'd9; bus.ifm_data = rand_vec(); bus.wgt_data = 8'h3C;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    total++; if (bus.pe_en !== '1 || bus.busy !== 1'b1 || bus.pe_finish !== '0) begin
      bad++; $display("FAIL abort_pre got en=%h busy=%0b fin=%h exp all-ones 1 0", bus.pe_en, bus.busy, bus.pe_finish); end
    reset = 1'b1; bus.ofm_rdy = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.pe_en !== '0 || bus.pe_finish !== '0 || bus.done !== 1'b0 || bus.ofm_vld !== 1'b0) begin
      bad++; $display("FAIL abort_ctl got busy=%0b en=%h fin=%h done=%0b vld=%0b exp 0", bus.busy, bus.pe_en, bus.pe_finish, bus.done, bus.ofm_vld); end
    total++; if (bus.pe_ifm !== '0 || bus.pe_weight !== '0 || bus.ofm_data !== '0 || bus.ifm_rdy !== 1'b0) begin
      bad++; $display("FAIL abort_data got w=%h ifm_lo=%h ofm_lo=%h rdy=%0b exp 0", bus.pe_weight, bus.pe_ifm[63:0], bus.ofm_data[63:0], bus.ifm_rdy); end
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pe_en !== '0) begin
        bad++; $display("FAIL abort_idle c=%0d got done=%0b busy=%0b en=%h exp 0", c, bus.done, bus.busy, bus.pe_en); end
    end
    bus.ifm_vld = 1'b0; bus.wgt_vld = 1'b0; bus.ofm_rdy = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job("random", $urandom_range(1, 12), ($urandom_range(3) == 0) ? '1 : rand_mask(),
              $urandom_range(2), $urandom_range(2), $urandom_range(0, 8), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 1, '1, 0, 0, 0, 0, 1'b0);
    run_job("b2b_b", 2, rand_mask(), 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mask();
    test_out_stall();
    test_timeout();
    test_zero_mask();
    test_abort_reset();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
